// File: rtl/mem_port_arbiter_if.sv
// Unified memory-port bus between the arbiter and the memory.
//   master : arbiter side, drives bus_req/wen/addr/wdata/wmask, receives gnt and the response.
//   slave  : memory side, the mirror image.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
);
  logic            bus_req;
  logic            bus_wen;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_wmask;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [DW-1:0]   bus_rdata;

  modport master (
    output bus_req, bus_wen, bus_addr, bus_wdata, bus_wmask,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wen, bus_addr, bus_wdata, bus_wmask,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   if_req/if_addr      fetch request (held until if_ack), if_flush cancels it
//   if_ack/if_instr     one-cycle fetch completion with the selected 32-bit word
//   mem_req/wen/addr/wdata/wmask  data request (held until mem_ack)
//   mem_ack/mem_rdata   one-cycle data completion, load data
//   if_stall/mem_stall  requester waiting (req & ~ack)
//   bus                 request/grant/response bus (master modport)
//   perf_if_wait/perf_mem_wait  free-running stall-cycle counters
module mem_port_arbiter #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [AW-1:0]        if_addr,
  input  logic                 if_flush,
  output logic                 if_ack,
  output logic [31:0]          if_instr,
  output logic                 if_stall,
  input  logic                 mem_req,
  input  logic                 mem_wen,
  input  logic [AW-1:0]        mem_addr,
  input  logic [DW-1:0]        mem_wdata,
  input  logic [DW/8-1:0]      mem_wmask,
  output logic                 mem_ack,
  output logic [DW-1:0]        mem_rdata,
  output logic                 mem_stall,
  mem_port_arbiter_if.master   bus,
  output logic [31:0]          perf_if_wait,
  output logic [31:0]          perf_mem_wait
);

  typedef enum logic [2:0] {IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D} arbStateT;

  arbStateT        state;
  logic            lastD;
  logic            drop;
  logic            hiWord;
  logic            busReq;
  logic            busWen;
  logic [AW-1:0]   busAddr;
  logic [DW-1:0]   busWdata;
  logic [DW/8-1:0] busWmask;
  logic            pickI;
  logic            pickD;
  logic            unusedAddrBits;

  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

  // A requester whose ack shows this cycle is still holding its finished request.
  assign pickI = if_stall & ~if_flush;
  assign pickD = mem_stall;

  assign unusedAddrBits = ^if_addr[1:0];

  assign bus.bus_req   = busReq;
  assign bus.bus_wen   = busWen;
  assign bus.bus_addr  = busAddr;
  assign bus.bus_wdata = busWdata;
  assign bus.bus_wmask = busWmask;

  // Arbitration FSM, bus request registers, returned data and perf counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      lastD         <= 1'b0;
      drop          <= 1'b0;
      hiWord        <= 1'b0;
      busReq        <= 1'b0;
      busWen        <= 1'b0;
      busAddr       <= '0;
      busWdata      <= '0;
      busWmask      <= '0;
      if_ack        <= 1'b0;
      if_instr      <= '0;
      mem_ack       <= 1'b0;
      mem_rdata     <= '0;
      perf_if_wait  <= '0;
      perf_mem_wait <= '0;
    end else begin
      if_ack        <= 1'b0;
      mem_ack       <= 1'b0;
      perf_if_wait  <= perf_if_wait + 32'(if_stall);
      perf_mem_wait <= perf_mem_wait + 32'(mem_stall);

      case (state)
        IDLE: begin
          // Data wins a tie unless the previous completion was also data.
          if (pickD && !(pickI && lastD)) begin
            state    <= REQ_D;
            busReq   <= 1'b1;
            busWen   <= mem_wen;
            busAddr  <= mem_addr;
            busWdata <= mem_wdata;
            busWmask <= mem_wmask;
          end else if (pickI) begin
            state    <= REQ_I;
            busReq   <= 1'b1;
            busWen   <= 1'b0;
            busAddr  <= {if_addr[AW-1:3], 3'b000};
            busWdata <= '0;
            busWmask <= '0;
            hiWord   <= if_addr[2];
          end
        end

        REQ_I: begin
          if (bus.bus_gnt) begin
            state  <= WAIT_I;
            busReq <= 1'b0;
            drop   <= if_flush;
          end else if (if_flush) begin
            state  <= IDLE;
            busReq <= 1'b0;
          end
        end

        WAIT_I: begin
          if (bus.bus_rvalid) begin
            state <= IDLE;
            drop  <= 1'b0;
            lastD <= 1'b0;
            // A flush arriving with the response still discards it.
            if (!(drop || if_flush)) begin
              if_ack   <= 1'b1;
              if_instr <= hiWord ? bus.bus_rdata[63:32] : bus.bus_rdata[31:0];
            end
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end

        REQ_D: begin
          if (bus.bus_gnt) begin
            state  <= WAIT_D;
            busReq <= 1'b0;
          end
        end

        WAIT_D: begin
          if (bus.bus_rvalid) begin
            state   <= IDLE;
            lastD   <= 1'b1;
            mem_ack <= 1'b1;
            if (!busWen) begin
              mem_rdata <= bus.bus_rdata;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_ack;
  logic [31:0]   if_instr;
  logic          if_stall;
  logic          mem_req;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_stall;
  logic [31:0]   perf_if_wait;
  logic [31:0]   perf_mem_wait;

  int vectors = 0;
  int miscompares = 0;
  bit checkOn = 1'b0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) busIf ();

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_flush     (if_flush),
    .if_ack       (if_ack),
    .if_instr     (if_instr),
    .if_stall     (if_stall),
    .mem_req      (mem_req),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .mem_stall    (mem_stall),
    .bus          (busIf.master),
    .perf_if_wait (perf_if_wait),
    .perf_mem_wait(perf_mem_wait)
  );

  always #5 clk = ~clk;

  // Model: the one outstanding transaction plus the values the requesters last saw.
  bit            txValid, txData, txGranted, txDropped, txHi;
  bit            lastWasData;
  logic          eWen;
  logic [AW-1:0] eAddr;
  logic [DW-1:0] eWdata;
  logic [MW-1:0] eWmask;
  logic          eIfAck, eMemAck;
  logic [31:0]   eInstr;
  logic [DW-1:0] eRdata;
  logic [31:0]   ePerfI, ePerfD;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit ackI, ackD, wantI, wantD;
    if (!rst) begin
      txValid = 0; txData = 0; txGranted = 0; txDropped = 0; txHi = 0;
      lastWasData = 0;
      eWen = 0; eAddr = '0; eWdata = '0; eWmask = '0;
      eIfAck = 0; eMemAck = 0; eInstr = '0; eRdata = '0;
      ePerfI = '0; ePerfD = '0;
    end else begin
      ackI = eIfAck;
      ackD = eMemAck;
      eIfAck = 0;
      eMemAck = 0;
      if (if_req && !ackI) ePerfI = ePerfI + 1;
      if (mem_req && !ackD) ePerfD = ePerfD + 1;
      if (!txValid) begin
        wantI = if_req && !ackI && !if_flush;
        wantD = mem_req && !ackD;
        if (wantD && !(wantI && lastWasData)) begin
          txValid = 1; txData = 1; txGranted = 0; txDropped = 0;
          eWen = mem_wen; eAddr = mem_addr; eWdata = mem_wdata; eWmask = mem_wmask;
        end else if (wantI) begin
          txValid = 1; txData = 0; txGranted = 0; txDropped = 0;
          txHi = if_addr[2];
          eWen = 0; eAddr = if_addr & ~64'h7; eWdata = '0; eWmask = '0;
        end
      end else if (!txGranted) begin
        if (busIf.bus_gnt) begin
          txGranted = 1;
          if (!txData && if_flush) txDropped = 1;
        end else if (!txData && if_flush) begin
          txValid = 0;
        end
      end else begin
        if (!txData && if_flush) txDropped = 1;
        if (busIf.bus_rvalid) begin
          txValid = 0;
          txGranted = 0;
          if (txData) begin
            eMemAck = 1;
            if (!eWen) eRdata = busIf.bus_rdata;
            lastWasData = 1;
          end else begin
            if (!txDropped) begin
              eIfAck = 1;
              eInstr = txHi ? busIf.bus_rdata[63:32] : busIf.bus_rdata[31:0];
            end
            lastWasData = 0;
          end
          txDropped = 0;
        end
      end
    end
  endtask

  // Inputs change 1 ns after the edge; the model advances at the edge.
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idleInputs();
    if_req = 0; if_addr = '0; if_flush = 0;
    mem_req = 0; mem_wen = 0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
    busIf.bus_gnt = 0; busIf.bus_rvalid = 0; busIf.bus_rdata = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      chk("bus_req", 64'(busIf.bus_req), 64'(txValid && !txGranted));
      chk("bus_wen", 64'(busIf.bus_wen), 64'(eWen));
      chk("bus_addr", busIf.bus_addr, eAddr);
      chk("bus_wdata", busIf.bus_wdata, eWdata);
      chk("bus_wmask", 64'(busIf.bus_wmask), 64'(eWmask));
      chk("if_ack", 64'(if_ack), 64'(eIfAck));
      chk("if_instr", 64'(if_instr), 64'(eInstr));
      chk("if_stall", 64'(if_stall), 64'(if_req && !eIfAck));
      chk("mem_ack", 64'(mem_ack), 64'(eMemAck));
      chk("mem_rdata", mem_rdata, eRdata);
      chk("mem_stall", 64'(mem_stall), 64'(mem_req && !eMemAck));
      chk("perf_if_wait", 64'(perf_if_wait), 64'(ePerfI));
      chk("perf_mem_wait", 64'(perf_mem_wait), 64'(ePerfD));
      chk("ack_exclusive", 64'(if_ack && mem_ack), 64'(0));
    end
  end

  initial begin
    idleInputs();
    rst = 0;
    tick();
    checkOn = 1;
    doReset();

    // Reset state
    chk("rst bus_req", 64'(busIf.bus_req), 64'(0));
    chk("rst if_ack", 64'(if_ack), 64'(0));
    chk("rst mem_ack", 64'(mem_ack), 64'(0));
    chk("rst perf_if", 64'(perf_if_wait), 64'(0));

    // Fetch only, upper word
    if_req = 1; if_addr = 64'h1004;
    tick();
    chk("f1 bus_req", 64'(busIf.bus_req), 64'(1));
    chk("f1 bus_addr", busIf.bus_addr, 64'h1000);
    chk("f1 model addr", eAddr, 64'h1000);
    busIf.bus_gnt = 1;
    tick();
    busIf.bus_gnt = 0; busIf.bus_rvalid = 1; busIf.bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    chk("f1 if_ack", 64'(if_ack), 64'(1));
    chk("f1 if_instr", 64'(if_instr), 64'hAAAABBBB);
    chk("f1 model instr", 64'(eInstr), 64'hAAAABBBB);
    chk("f1 perf_if", 64'(perf_if_wait), 64'(3));
    if_req = 0; busIf.bus_rvalid = 0;
    tick();
    chk("f1 ack pulse", 64'(if_ack), 64'(0));

    // Both requesting: data first, then fetch before the next data access
    doReset();
    if_req = 1; if_addr = 64'h40;
    mem_req = 1; mem_wen = 0; mem_addr = 64'h80;
    tick();
    chk("b1 bus_addr", busIf.bus_addr, 64'h80);
    busIf.bus_gnt = 1;
    tick();
    busIf.bus_gnt = 0; busIf.bus_rvalid = 1; busIf.bus_rdata = 64'h1111_2222_3333_4444;
    tick();
    chk("b1 mem_ack", 64'(mem_ack), 64'(1));
    chk("b1 mem_rdata", mem_rdata, 64'h1111_2222_3333_4444);
    busIf.bus_rvalid = 0; mem_addr = 64'h88;
    tick();
    chk("b2 fetch first", busIf.bus_addr, 64'h40);
    busIf.bus_gnt = 1;
    tick();
    busIf.bus_gnt = 0; busIf.bus_rvalid = 1; busIf.bus_rdata = 64'h5555_6666_7777_8888;
    tick();
    chk("b2 if_instr", 64'(if_instr), 64'h77778888);
    if_req = 0; busIf.bus_rvalid = 0;
    tick();
    chk("b3 bus_addr", busIf.bus_addr, 64'h88);
    busIf.bus_gnt = 1;
    tick();
    busIf.bus_gnt = 0; busIf.bus_rvalid = 1; busIf.bus_rdata = 64'h0BAD_F00D_1234_5678;
    tick();
    chk("b3 mem_rdata", mem_rdata, 64'h0BAD_F00D_1234_5678);
    mem_req = 0; busIf.bus_rvalid = 0;
    tick();

    // Store with grant delayed four REQ cycles
    mem_req = 1; mem_wen = 1; mem_addr = 64'h2000;
    mem_wdata = 64'h1122_3344_5566_7788; mem_wmask = 8'h0F;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("s1 bus_req", 64'(busIf.bus_req), 64'(1));
      chk("s1 bus_addr", busIf.bus_addr, 64'h2000);
      chk("s1 bus_wdata", busIf.bus_wdata, 64'h1122_3344_5566_7788);
      chk("s1 bus_wmask", 64'(busIf.bus_wmask), 64'h0F);
      chk("s1 bus_wen", 64'(busIf.bus_wen), 64'(1));
      busIf.bus_gnt = (i == 3);
      tick();
    end
    busIf.bus_gnt = 0; busIf.bus_rvalid = 1; busIf.bus_rdata = 64'hFFFF_0000_FFFF_0000;
    tick();
    chk("s1 mem_ack", 64'(mem_ack), 64'(1));
    chk("s1 rdata held", mem_rdata, 64'h0BAD_F00D_1234_5678);
    mem_req = 0; busIf.bus_rvalid = 0;
    tick();
    chk("s1 single ack", 64'(mem_ack), 64'(0));

    // Flush in WAIT_I drops the response; the redirected fetch completes
    if_req = 1; if_addr = 64'h500;
    tick();
    busIf.bus_gnt = 1;
    tick();
    busIf.bus_gnt = 0; if_flush = 1; if_addr = 64'h3000;
    tick();
    if_flush = 0; busIf.bus_rvalid = 1; busIf.bus_rdata = 64'h1234;
    tick();
    chk("w1 no if_ack", 64'(if_ack), 64'(0));
    busIf.bus_rvalid = 0;
    tick();
    chk("w1 refetch addr", busIf.bus_addr, 64'h3000);
    busIf.bus_gnt = 1;
    tick();
    busIf.bus_gnt = 0; busIf.bus_rvalid = 1; busIf.bus_rdata = 64'h9999_AAAA_7777_8888;
    tick();
    chk("w1 if_ack", 64'(if_ack), 64'(1));
    chk("w1 if_instr", 64'(if_instr), 64'h77778888);
    if_req = 0; busIf.bus_rvalid = 0;
    tick();

    // Flush in REQ_I without grant aborts the request
    if_req = 1; if_addr = 64'h600;
    tick();
    chk("r1 bus_req", 64'(busIf.bus_req), 64'(1));
    if_flush = 1; if_req = 0;
    tick();
    chk("r1 bus_req drop", 64'(busIf.bus_req), 64'(0));
    if_flush = 0; busIf.bus_rvalid = 1;
    tick();
    chk("r1 bus_req idle", 64'(busIf.bus_req), 64'(0));
    chk("r1 no if_ack", 64'(if_ack), 64'(0));
    busIf.bus_rvalid = 0;

    // Reset during WAIT_D; the late response is ignored
    mem_req = 1; mem_wen = 0; mem_addr = 64'h700;
    tick();
    busIf.bus_gnt = 1;
    tick();
    busIf.bus_gnt = 0; rst = 0; mem_req = 0;
    tick();
    rst = 1; busIf.bus_rvalid = 1; busIf.bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    chk("x1 mem_ack", 64'(mem_ack), 64'(0));
    chk("x1 mem_rdata", mem_rdata, 64'(0));
    chk("x1 if_instr", 64'(if_instr), 64'(0));
    chk("x1 perf_mem", 64'(perf_mem_wait), 64'(0));
    chk("x1 perf_if", 64'(perf_if_wait), 64'(0));
    chk("x1 bus_addr", busIf.bus_addr, 64'(0));
    chk("x1 bus_wdata", busIf.bus_wdata, 64'(0));
    chk("x1 bus_req", 64'(busIf.bus_req), 64'(0));
    busIf.bus_rvalid = 0; if_req = 1; if_addr = 64'h800;
    tick();
    chk("x1 idle pick", busIf.bus_addr, 64'h800);
    busIf.bus_gnt = 1;
    tick();
    busIf.bus_gnt = 0; busIf.bus_rvalid = 1;
    tick();
    if_req = 0; busIf.bus_rvalid = 0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 5000; c++) begin
      busIf.bus_gnt    = (txValid && !txGranted) ? ($urandom % 3 == 0) : 1'b0;
      busIf.bus_rvalid = ($urandom % 3 == 0);
      busIf.bus_rdata  = {$urandom, $urandom};
      if_flush = 0;
      if (!if_req || eIfAck) begin
        if_req  = ($urandom % 3 != 0);
        if_addr = {32'h0, $urandom} & ~64'h3;
      end else if ($urandom % 12 == 0) begin
        if_flush = 1;
        if_addr  = {32'h0, $urandom} & ~64'h3;
      end
      if (!mem_req || eMemAck) begin
        mem_req   = ($urandom % 3 != 0);
        mem_wen   = ($urandom % 2 == 0);
        mem_addr  = {$urandom, $urandom};
        mem_wdata = {$urandom, $urandom};
        mem_wmask = MW'($urandom);
      end
      rst = ($urandom % 700 != 0);
      tick();
    end

    rst = 1;
    idleInputs();
    tick();
    tick();
    checkOn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the five-stage pipeline.
- Sequences each transaction over a request/grant/response bus that may take several cycles.
- Returns the fetched instruction or the load data to its requester.
- Produces the stall signals that the hazard controller ORs into its F/D and M-stage stalls.

Parameters:
- AW, 64, address width.
- DW, 64, bus data width; byte-mask width is DW/8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (sampled on the rising edge of clk).
- if_req  in  1  fetch request; held high with if_addr until if_ack.
- if_addr  in  AW  fetch address, 4-byte aligned.
- if_flush  in  1  one-cycle pulse: cancel the current fetch (branch redirect).
- if_ack  out  1  one-cycle pulse: if_instr is valid.
- if_instr  out  32  instruction word.
- if_stall  out  1  if_req & ~if_ack.
- mem_req  in  1  data request; held high with the other mem_* inputs until mem_ack.
- mem_wen  in  1  1 = store, 0 = load.
- mem_addr  in  AW  data address.
- mem_wdata  in  DW  store data.
- mem_wmask  in  DW/8  store byte mask.
- mem_ack  out  1  one-cycle pulse: load data valid, or store done.
- mem_rdata  out  DW  load data.
- mem_stall  out  1  mem_req & ~mem_ack.
- bus_req  out  1  bus request.
- bus_wen  out  1  bus write enable.
- bus_addr  out  AW  bus address.
- bus_wdata  out  DW  bus write data.
- bus_wmask  out  DW/8  bus byte mask.
- bus_gnt  in  1  bus accepted the request this cycle.
- bus_rvalid  in  1  response valid (loads, fetches and stores all respond).
- bus_rdata  in  DW  response data.
- perf_if_wait  out  32  count of cycles with if_stall=1.
- perf_mem_wait  out  32  count of cycles with mem_stall=1.

Behaviour:
- Reset (rst=0 at a clock edge), regardless of any transaction in flight:
  - state=IDLE, last_d=0, drop=0, both perf counters=0.
  - bus_req=0, if_ack=0, mem_ack=0.
  - if_instr=0, mem_rdata=0, bus_addr/wdata/wmask/wen=0.
  - A bus response arriving after reset is ignored.
- FSM states: IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D.
- IDLE, choosing the next requester:
  - Only mem_req high -> REQ_D.
  - Only if_req high (and if_flush=0) -> REQ_I.
  - Both high: REQ_D unless last_d=1, in which case REQ_I.
  - If if_flush=1 in IDLE, the fetch is not picked that cycle.
- REQ_x:
  - bus_req=1; bus_* driven from registers captured on entry.
  - Fetch: bus_wen=0, bus_wmask=0, address = if_addr with bits[2:0] cleared.
  - bus_gnt=1 -> WAIT_x. Otherwise hold all bus_* stable and stay.
- WAIT_x:
  - bus_req=0.
  - On bus_rvalid -> IDLE and pulse the matching ack for exactly one cycle (the cycle after rvalid).
  - Fetch data: if_instr = bus_rdata[63:32] if the captured addr[2]=1, else bus_rdata[31:0].
  - Load data: mem_rdata = bus_rdata. Store: mem_ack only; mem_rdata holds its previous value.
  - Minimum latency from request seen in IDLE to ack: 3 cycles (IDLE->REQ with gnt in the first REQ cycle, rvalid in the first WAIT cycle, ack the next cycle).
- last_d update: set to 1 on completion of a data transaction, cleared on completion of a fetch. A waiting fetch is therefore never starved by back-to-back data accesses.
- if_flush:
  - In REQ_I with bus_gnt=0: abort, go to IDLE; no bus transaction issued, no if_ack.
  - In REQ_I with bus_gnt=1, or in WAIT_I: set drop=1. The response is consumed, no if_ack is generated, drop clears, and the FSM returns to IDLE.
  - Flush during REQ_D/WAIT_D has no effect on the data transaction.
- if_ack and mem_ack are never high together; neither is ever high for two consecutive cycles from one transaction.
- Requester inputs are sampled only when entering REQ_x; changes while the transaction is outstanding are ignored.
- Perf counters increment by 1 per cycle their stall is high, wrap 0xFFFFFFFF->0, and never reset except by rst.
- bus_rvalid outside WAIT_x is ignored.

Test Plan:
- Fetch only: if_addr=0x1004, gnt in first REQ cycle, rvalid next cycle with rdata=0xAAAA_BBBB_CCCC_DDDD -> bus_addr=0x1000, if_ack pulses 3 cycles after if_req, if_instr=0xAAAABBBB, perf_if_wait=3.
- Both requesting from IDLE after reset -> data served first. A second back-to-back mem_req with if_req still high -> fetch is served before the second data access.
- Store: mem_wen=1, mem_addr=0x2000, mem_wdata=0x1122334455667788, mem_wmask=0x0F, gnt delayed 4 cycles -> bus_* stable through all 4 REQ cycles, single mem_ack, mem_rdata unchanged.
- if_flush in WAIT_I, followed by rvalid=1 with rdata=0x1234 -> no if_ack. A new fetch to 0x3000 then completes normally with its own data.
- if_flush in REQ_I with gnt=0 -> FSM returns to IDLE, bus_req drops next cycle, no bus transaction issued.
- rst=0 asserted in WAIT_D, then a late rvalid -> no mem_ack, state IDLE, perf counters 0, all outputs at reset values.
